demux_capture: RTL and testbench
================================

DEMUX_CAPTURE -- requirements
Module: demux_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each per-channel event counter (legal range 2..16).
REQ-002 SHALL have parameter RD_CLR, default 1; when 1, a read clears the counter that was read.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  8  channel lines from the upstream 1:8 demux out[7:0]; may be asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of all counters and flags.
REQ-007 rd_req  input  1  single-cycle read request.
REQ-008 rd_sel  input  3  channel index to read; sampled with rd_req.
REQ-009 rd_data  output  CNT_W  count of the channel that was read.
REQ-010 rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-011 ovf  output  8  per-channel sticky overflow flag.

Function
REQ-012 SHALL pass each din bit through a 2-flop synchroniser, then a third flop for edge detection; rising edges only count.
REQ-013 Latency from a din rising edge to the counter increment SHALL be 3 clk cycles; pulses shorter than one clk period are not guaranteed to count.
REQ-014 Each rising edge SHALL increment that channel's counter by exactly 1; channels count independently and simultaneously.
REQ-015 A read SHALL return the counter value before any same-cycle update: rd_req and rd_sel are sampled in cycle N; rd_data and rd_valid=1 are presented in cycle N+1.
REQ-016 rd_valid SHALL be 0 in every cycle not following a sampled rd_req; rd_data SHALL hold its last value when rd_valid=0.
REQ-017 Back-to-back rd_req on consecutive cycles SHALL each be serviced, giving consecutive rd_valid strobes.
REQ-018 With RD_CLR=1, a read SHALL clear the read counter and its ovf bit; if an increment on that channel coincides, the counter SHALL become 1 after the cycle.
REQ-019 At a counter value of 2^CNT_W-1, an increment SHALL set the ovf bit; the wrap/saturate behaviour is given in REQ-024.
REQ-020 clr SHALL zero all counters and ovf bits and SHALL take priority over a coincident increment and a coincident read-clear; a coincident read SHALL still return the pre-clear value.
REQ-021 The synchroniser and edge flops SHALL NOT be affected by clr.

Reset
REQ-022 While rst=1, all counters SHALL be 0, ovf=8'h00, rd_valid=0 and rd_data=0, and synchroniser/edge flops SHALL be 0; this takes effect immediately without waiting for clk.
REQ-023 A din line that is held high across reset release SHALL count one edge after its synchroniser fills; a read pending at reset assertion SHALL be dropped.

Configuration
REQ-024 Macro DEMUX_CAPTURE_SATURATE_EN: when defined, counters SHALL hold at 2^CNT_W-1 on overflow; when undefined, they SHALL wrap to 0. ovf SHALL set in both cases.

Structure
REQ-025 Package demux_capture_pkg SHALL hold NUM_CH=8, SEL_W=3 and the default CNT_W constant.
REQ-026 The block SHALL use one sub-module, capture_chan (synchroniser, edge detect, counter, ovf), instantiated 8 times and indexed by channel.

Verification
REQ-027 Reset, then 5 pulses on din[3], then a read with rd_sel=3 -> rd_data=5 and rd_valid one cycle after rd_req; a following read returns 0 (RD_CLR=1).
REQ-028 CNT_W=8 with 256 pulses on din[0] -> ovf[0]=1; rd_data=0 without the macro, or 255 with DEMUX_CAPTURE_SATURATE_EN defined.
REQ-029 Read-clear of channel 2 when the count is 7 and an edge arrives in the same cycle -> rd_data=7 and the counter then reads 1.
REQ-030 Pulses on all 8 channels in the same cycle, 3 times -> every channel reads 3; clr asserted together with rd_req -> the pre-clear value is returned and all counters then read 0.
REQ-031 rst asserted mid-count between clk edges -> all outputs are 0 immediately; rd_valid stays 0 for the pending read.

Source files
------------

// File: rtl/demux_capture_pkg.sv
// demux_capture_pkg: shared constants for the demux capture block (channel count, select width, default counter width)
package demux_capture_pkg;
    localparam int NUM_CH    = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux_capture_if.sv
// demux_capture_if: counter read port
//   rd_req   single-cycle read request (master -> slave)
//   rd_sel   channel to read, sampled with rd_req (master -> slave)
//   rd_data  count of the channel read (slave -> master)
//   rd_valid one-cycle strobe qualifying rd_data (slave -> master)
interface demux_capture_if
    import demux_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (output rd_req, rd_sel, input rd_data, rd_valid);
    modport slave  (input rd_req, rd_sel, output rd_data, rd_valid);
endinterface

// File: rtl/demux_capture_chan.sv
// capture_chan: one channel of the capture block -- synchroniser, rising-edge detect, event counter, sticky overflow
//   clk, rst  clock and asynchronous active-high reset
//   din       raw channel line, may be asynchronous to clk
//   clr       synchronous clear of cnt/ovf (synchroniser untouched)
//   rd_clr    read-clear of this channel
//   cnt, ovf  event count and sticky overflow flag
// DEMUX_CAPTURE_SATURATE_EN: when defined the counter holds at its maximum instead of wrapping.
module capture_chan
    import demux_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr,
    input  logic             rd_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
`ifdef DEMUX_CAPTURE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // sync[1:0] is the 2-flop synchroniser, sync[2] the edge-detect delay
    logic [2:0]       sync;
    logic             rise;
    logic             full;
    logic [CNT_W-1:0] inc_val;

    assign rise    = sync[1] & ~sync[2];
    assign full    = &cnt;
    assign inc_val = full ? (SAT ? cnt : '0) : cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], din};

    // clr beats read-clear beats increment; a read-clear with a coincident edge leaves 1
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (rd_clr) begin
            cnt <= CNT_W'(rise);
            ovf <= 1'b0;
        end else if (rise) begin
            cnt <= inc_val;
            ovf <= ovf | full;
        end
endmodule

// File: rtl/demux_capture.sv
// demux_capture: counts rising edges on the 8 outputs of an upstream 1:8 demux, with a registered read port
//   clk, rst  clock and asynchronous active-high reset
//   din       8 channel lines (asynchronous)
//   clr       synchronous clear of all counters and ovf flags
//   rd        read port (demux_capture_if.slave): rd_req/rd_sel in, rd_data/rd_valid one cycle later
//   ovf       per-channel sticky overflow flags
// Parameters: CNT_W counter width, RD_CLR=1 makes a read clear the channel read.
// DEMUX_CAPTURE_SATURATE_EN (in capture_chan): saturate instead of wrap on overflow.
module demux_capture
    import demux_capture_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter bit RD_CLR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] din,
    input  logic              clr,
    demux_capture_if.slave    rd,
    output logic [NUM_CH-1:0] ovf
);
    logic [CNT_W-1:0] cnt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        capture_chan #(.CNT_W(CNT_W)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .din    (din[i]),
            .clr    (clr),
            .rd_clr (RD_CLR && rd.rd_req && rd.rd_sel == SEL_W'(i)),
            .cnt    (cnt[i]),
            .ovf    (ovf[i])
        );
    end

    // cnt is sampled before this edge's update, so a read returns the pre-clear/pre-increment value
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_req;
            if (rd.rd_req) rd.rd_data <= cnt[rd.rd_sel];
        end
endmodule

// File: tb/tb_demux_capture.sv
// tb_demux_capture: directed self-checking bench for demux_capture (CNT_W=8, RD_CLR=1)
module tb_demux_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       clr = 1'b0;
    logic [7:0] ovf;
    int         checks = 0;
    int         failures = 0;

    demux_capture_if #(.CNT_W(8)) rd ();

    demux_capture #(.CNT_W(8), .RD_CLR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .clr (clr),
        .rd  (rd),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

`ifdef DEMUX_CAPTURE_SATURATE_EN
    localparam logic [7:0] WRAP_VAL = 8'd255;
`else
    localparam logic [7:0] WRAP_VAL = 8'd0;
`endif

    task automatic pulse(input logic [7:0] m, input int n);
        repeat (n) begin
            din = m;
            repeat (2) @(negedge clk);
            din = '0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_read(input logic [2:0] s, output logic v, output logic [7:0] d);
        rd.rd_req = 1'b1;
        rd.rd_sel = s;
        @(negedge clk);
        rd.rd_req = 1'b0;
        v = rd.rd_valid;
        d = rd.rd_data;
    endtask

    task automatic test_reset;
        rd.rd_req = 1'b0;
        rd.rd_sel = '0;
        #1;
        checks++;
        if (rd.rd_valid !== 1'b0 || rd.rd_data !== 8'd0 || ovf !== 8'h00) begin
            failures++;
            $display("FAIL reset: valid=%b data=%0d ovf=%h want 0/0/00", rd.rd_valid, rd.rd_data, ovf);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count;
        logic v;
        logic [7:0] d;
        pulse(8'h08, 5);
        do_read(3'd3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 8'd5) begin
            failures++;
            $display("FAIL count5: valid=%b data=%0d want 1/5", v, d);
        end
        @(negedge clk);
        checks++;
        if (rd.rd_valid !== 1'b0 || rd.rd_data !== 8'd5) begin
            failures++;
            $display("FAIL idle_hold: valid=%b data=%0d want 0/5", rd.rd_valid, rd.rd_data);
        end
        do_read(3'd3, v, d);
        checks++;
        if (v !== 1'b1 || d !== 8'd0) begin
            failures++;
            $display("FAIL read_clear: valid=%b data=%0d want 1/0", v, d);
        end
    endtask

    task automatic test_overflow;
        logic v;
        logic [7:0] d;
        pulse(8'h01, 255);
        checks++;
        if (ovf !== 8'h00) begin
            failures++;
            $display("FAIL ovf_255: ovf=%h want 00", ovf);
        end
        pulse(8'h01, 1);
        checks++;
        if (ovf !== 8'h01) begin
            failures++;
            $display("FAIL ovf_256: ovf=%h want 01", ovf);
        end
        do_read(3'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== WRAP_VAL) begin
            failures++;
            $display("FAIL ovf_read: valid=%b data=%0d want 1/%0d", v, d, WRAP_VAL);
        end
        checks++;
        if (ovf !== 8'h00) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%h want 00", ovf);
        end
    endtask

    task automatic test_coincident;
        logic v;
        logic [7:0] d;
        pulse(8'h04, 7);
        // edge reaches the counter on the third rising clk after din rises
        din = 8'h04;
        repeat (2) @(negedge clk);
        rd.rd_req = 1'b1;
        rd.rd_sel = 3'd2;
        @(negedge clk);
        rd.rd_req = 1'b0;
        checks++;
        if (rd.rd_valid !== 1'b1 || rd.rd_data !== 8'd7) begin
            failures++;
            $display("FAIL coinc_read: valid=%b data=%0d want 1/7", rd.rd_valid, rd.rd_data);
        end
        din = '0;
        repeat (4) @(negedge clk);
        do_read(3'd2, v, d);
        checks++;
        if (d !== 8'd1) begin
            failures++;
            $display("FAIL coinc_after: data=%0d want 1", d);
        end
    endtask

    task automatic test_back_to_back;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pulse(8'hFF, 3);
        rd.rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd.rd_sel = 3'(i);
            @(negedge clk);
            checks++;
            if (rd.rd_valid !== 1'b1 || rd.rd_data !== 8'd3) begin
                failures++;
                $display("FAIL b2b_ch%0d: valid=%b data=%0d want 1/3", i, rd.rd_valid, rd.rd_data);
            end
        end
        rd.rd_req = 1'b0;
    endtask

    task automatic test_clr;
        pulse(8'hFF, 3);
        rd.rd_req = 1'b1;
        rd.rd_sel = 3'd7;
        clr = 1'b1;
        @(negedge clk);
        rd.rd_req = 1'b0;
        clr = 1'b0;
        checks++;
        if (rd.rd_valid !== 1'b1 || rd.rd_data !== 8'd3) begin
            failures++;
            $display("FAIL clr_read: valid=%b data=%0d want 1/3", rd.rd_valid, rd.rd_data);
        end
        rd.rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd.rd_sel = 3'(i);
            @(negedge clk);
            checks++;
            if (rd.rd_valid !== 1'b1 || rd.rd_data !== 8'd0) begin
                failures++;
                $display("FAIL clr_ch%0d: valid=%b data=%0d want 1/0", i, rd.rd_valid, rd.rd_data);
            end
        end
        rd.rd_req = 1'b0;
    endtask

    task automatic test_async_reset;
        logic v;
        logic [7:0] d;
        pulse(8'h02, 2);
        din = 8'h10;
        repeat (4) @(negedge clk);
        rd.rd_req = 1'b1;
        rd.rd_sel = 3'd1;
        @(negedge clk);
        checks++;
        if (rd.rd_valid !== 1'b1 || rd.rd_data !== 8'd2) begin
            failures++;
            $display("FAIL pre_rst: valid=%b data=%0d want 1/2", rd.rd_valid, rd.rd_data);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rd.rd_valid !== 1'b0 || rd.rd_data !== 8'd0 || ovf !== 8'h00) begin
            failures++;
            $display("FAIL async_rst: valid=%b data=%0d ovf=%h want 0/0/00", rd.rd_valid, rd.rd_data, ovf);
        end
        @(negedge clk);
        checks++;
        if (rd.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL pending_drop: valid=%b want 0", rd.rd_valid);
        end
        rd.rd_req = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_read(3'd4, v, d);
        checks++;
        if (v !== 1'b1 || d !== 8'd1) begin
            failures++;
            $display("FAIL held_high: valid=%b data=%0d want 1/1", v, d);
        end
        do_read(3'd1, v, d);
        checks++;
        if (d !== 8'd0) begin
            failures++;
            $display("FAIL rst_cleared: data=%0d want 0", d);
        end
        din = '0;
    endtask

    initial begin
        test_reset;
        test_count;
        test_overflow;
        test_coincident;
        test_back_to_back;
        test_clr;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
